// File: rtl/wrap_monitor.sv
// ---------------------------------------------------------------------------
// wrap_monitor
//
// Watches the sample stream of an upstream bounded counter that is expected
// to count lower_bound, lower_bound+1, ..., upper_bound, lower_bound, ...
// It locks onto the first legal sample, then checks every following valid
// sample against the expected successor. Each upper->lower wrap is counted
// in a saturating counter. Any illegal sample latches a sticky error and
// parks the monitor in FAULT until clear.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-low reset
//   count_in     in   DATA_WIDTH  sample from the upstream counter (unsigned)
//   valid_in     in   count_in is sampled this cycle
//   lower_bound  in   DATA_WIDTH  lowest legal count (unsigned)
//   upper_bound  in   DATA_WIDTH  highest legal count (unsigned)
//   clear        in   synchronous clear of errors/counter, re-acquire
//   wrap_pulse   out  one-cycle pulse per detected wrap
//   wrap_count   out  WRAP_WIDTH  wraps since reset/clear, saturating
//   wrap_sat     out  wrap_count has reached all-ones
//   locked       out  monitor is tracking the stream
//   err_range    out  sticky: out-of-range sample or inverted bounds
//   err_step     out  sticky: in-range sample that is not the successor
// ---------------------------------------------------------------------------
module wrap_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int WRAP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] count_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] lower_bound,
  input  logic [DATA_WIDTH-1:0] upper_bound,
  input  logic                  clear,
  output logic                  wrap_pulse,
  output logic [WRAP_WIDTH-1:0] wrap_count,
  output logic                  wrap_sat,
  output logic                  locked,
  output logic                  err_range,
  output logic                  err_step
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH:0] ONE_EXT = {{DATA_WIDTH{1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones instead of rolling over.
  function automatic logic [WRAP_WIDTH-1:0] sat_inc(input logic [WRAP_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + WRAP_WIDTH'(1);
  endfunction

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_prev, w_prev_nxt;
  logic                  r_wrap_pulse, w_wrap_pulse_nxt;
  logic [WRAP_WIDTH-1:0] r_wrap_count, w_wrap_count_nxt;
  logic                  r_wrap_sat, w_wrap_sat_nxt;
  logic                  r_locked;
  logic                  r_err_range, w_err_range_nxt;
  logic                  r_err_step, w_err_step_nxt;

  logic                  w_bounds_ok;
  logic                  w_in_range;
  logic                  w_prev_at_top;
  logic [DATA_WIDTH:0]   w_expected;
  logic                  w_match;
  logic                  w_wrap;
  logic [WRAP_WIDTH-1:0] w_count_inc;

  // Inverted bounds make every sample illegal.
  assign w_bounds_ok   = (lower_bound <= upper_bound);
  assign w_in_range    = w_bounds_ok && (count_in >= lower_bound) && (count_in <= upper_bound);
  assign w_prev_at_top = (r_prev == upper_bound);
  // One extra bit so prev+1 cannot overflow when prev is all-ones.
  assign w_expected    = w_prev_at_top ? {1'b0, lower_bound} : ({1'b0, r_prev} + ONE_EXT);
  assign w_match       = ({1'b0, count_in} == w_expected);
  // With lower == upper every in-range sample in TRACK is a wrap.
  assign w_wrap        = w_prev_at_top && (count_in == lower_bound);
  assign w_count_inc   = sat_inc(r_wrap_count);

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_wrap_pulse_nxt = 1'b0;
    w_wrap_count_nxt = r_wrap_count;
    w_wrap_sat_nxt   = r_wrap_sat;
    w_err_range_nxt  = r_err_range;
    w_err_step_nxt   = r_err_step;

    if (clear) begin
      // The sample presented alongside clear is deliberately dropped.
      w_state_nxt      = ACQUIRE;
      w_wrap_count_nxt = '0;
      w_wrap_sat_nxt   = 1'b0;
      w_err_range_nxt  = 1'b0;
      w_err_step_nxt   = 1'b0;
    end else begin
      case (r_state)
        ACQUIRE: begin
          if (valid_in) begin
            if (w_in_range) begin
              w_prev_nxt  = count_in;
              w_state_nxt = TRACK;
            end else begin
              w_err_range_nxt = 1'b1;
              w_state_nxt     = FAULT;
            end
          end
        end
        TRACK: begin
          if (valid_in) begin
            if (!w_in_range) begin
              w_err_range_nxt = 1'b1;
              w_state_nxt     = FAULT;
            end else if (w_match) begin
              w_prev_nxt = count_in;
              if (w_wrap) begin
                w_wrap_pulse_nxt = 1'b1;
                w_wrap_count_nxt = w_count_inc;
                w_wrap_sat_nxt   = r_wrap_sat | (&w_count_inc);
              end
            end else begin
              w_err_step_nxt = 1'b1;
              w_state_nxt    = FAULT;
            end
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = ACQUIRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ACQUIRE;
      r_prev       <= '0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
      r_wrap_sat   <= 1'b0;
      r_locked     <= 1'b0;
      r_err_range  <= 1'b0;
      r_err_step   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_wrap_sat   <= w_wrap_sat_nxt;
      r_locked     <= (w_state_nxt == TRACK);
      r_err_range  <= w_err_range_nxt;
      r_err_step   <= w_err_step_nxt;
    end
  end

  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;
  assign wrap_sat   = r_wrap_sat;
  assign locked     = r_locked;
  assign err_range  = r_err_range;
  assign err_step   = r_err_step;

endmodule
